// File: rtl/adder_seq_pkg.sv
// Shared types and constants for the multi-precision add/subtract sequencer.
// Optional signed-overflow output is enabled by defining ADDER_SEQ_OVF_EN.
package adder_seq_pkg;

    localparam int unsigned SLICE_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

    // Slice counter width; a single-slice build still needs a 1-bit counter.
    function automatic int unsigned idx_width(int unsigned nslice);
        return (nslice > 1) ? $clog2(nslice) : 1;
    endfunction

endpackage

// File: rtl/adder_slice_8c.sv
// Combinational 8-bit ripple-carry slice; c7 is the carry into the top bit, used for
// signed overflow when ADDER_SEQ_OVF_EN is defined in the controller.
module adder_slice_8c
    import adder_seq_pkg::*;
(
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               cin,
    output logic [SLICE_W-1:0] sum,
    output logic               cout,
    output logic               c7
);

    logic [SLICE_W:0] c;

    always_comb begin
        sum  = '0;
        c    = '0;
        c[0] = cin;
        for (int i = 0; i < SLICE_W; i++) begin
            sum[i]   = a[i] ^ b[i] ^ c[i];
            c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
    end

    assign cout = c[SLICE_W];
    assign c7   = c[SLICE_W-1];

endmodule

// File: rtl/adder_seq_ctrl.sv
// Sequencer that reuses one 8-bit slice to add/subtract WIDTH-bit operands over NSLICE cycles.
// Define ADDER_SEQ_OVF_EN to add the registered signed-overflow output out_ovf.
module adder_seq_ctrl
    import adder_seq_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout
`ifdef ADDER_SEQ_OVF_EN
    ,
    output logic             out_ovf
`endif
);

    localparam int unsigned NSLICE = WIDTH / SLICE_W;
    localparam int unsigned IDX_W = idx_width(NSLICE);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               carry_q, carry_d;
    logic               cout_q, cout_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [SLICE_W-1:0] slice_sum;
    logic               slice_cout;
    logic               slice_c7;
`ifdef ADDER_SEQ_OVF_EN
    logic               ovf_q, ovf_d;
`else
    logic               unused_c7;
    assign unused_c7 = slice_c7;
`endif

    adder_slice_8c u_slice (
        .a    (a_q[int'(idx_q) * SLICE_W +: SLICE_W]),
        .b    (b_q[int'(idx_q) * SLICE_W +: SLICE_W]),
        .cin  (carry_q),
        .sum  (slice_sum),
        .cout (slice_cout),
        .c7   (slice_c7)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            idx_q   <= '0;
`ifdef ADDER_SEQ_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            idx_q   <= idx_d;
`ifdef ADDER_SEQ_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        idx_d   = idx_q;
`ifdef ADDER_SEQ_OVF_EN
        ovf_d   = ovf_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    // Subtraction as A + ~B + 1: invert B here, the +1 enters as carry-in.
                    a_d     = in_a;
                    b_d     = in_b ^ {WIDTH{in_sub}};
                    carry_d = in_sub;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_d[int'(idx_q) * SLICE_W +: SLICE_W] = slice_sum;
                carry_d = slice_cout;
                if (idx_q == LAST_IDX) begin
                    idx_d   = '0;
                    cout_d  = slice_cout;
`ifdef ADDER_SEQ_OVF_EN
                    ovf_d   = slice_c7 ^ slice_cout;
`endif
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign out_sum   = sum_q;
    assign out_cout  = cout_q;
`ifdef ADDER_SEQ_OVF_EN
    assign out_ovf   = ovf_q;
`endif

endmodule

// File: tb/tb_adder_seq_ctrl.sv
// Randomized and directed bench for adder_seq_ctrl against an arithmetic reference model.
// With ADDER_SEQ_OVF_EN defined, out_ovf is also checked and a WIDTH=8 instance is exercised.
module tb_adder_seq_ctrl;

    localparam int W  = 32;
    localparam int NS = W / 8;

    typedef struct {
        logic [63:0] sum;
        logic        cout;
        logic        ovf;
    } res_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_a = '0;
    logic [W-1:0] in_b = '0;
    logic         in_sub = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] out_sum;
    logic         out_cout;
`ifdef ADDER_SEQ_OVF_EN
    logic         out_ovf;
`endif

    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   acc_cyc = 0;
    int   prev_acc = 0;
    int   acc_count = 0;
    int   done_count = 0;
    int   b2b_acc = 0;
    bit   b2b = 1'b0;
    bit   pv = 1'b0;
    res_t expq[$];

    always #5 clk = ~clk;

    adder_seq_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_sub    (in_sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout)
`ifdef ADDER_SEQ_OVF_EN
        ,
        .out_ovf   (out_ovf)
`endif
    );

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: plain integer arithmetic on n-bit operands.
    function automatic res_t model(logic [63:0] a, logic [63:0] b, logic sub, int n);
        res_t        m;
        logic [63:0] mask;
        longint      sa, sb, r, lim;
        mask   = (64'd1 << n) - 64'd1;
        m.sum  = (sub ? a - b : a + b) & mask;
        m.cout = sub ? (a >= b) : ((a + b) > mask);
        lim    = longint'(1) << (n - 1);
        sa     = a[n-1] ? longint'(a) - (lim << 1) : longint'(a);
        sb     = b[n-1] ? longint'(b) - (lim << 1) : longint'(b);
        r      = sub ? sa - sb : sa + sb;
        m.ovf  = (r > lim - 1) || (r < -lim);
        return m;
    endfunction

    // Handshake monitor: queue expected results at accept, retire them at consume.
    initial forever begin
        @(posedge clk);
        if (!rst_n) begin
            expq.delete();
        end else begin
            cyc++;
            if (out_valid && out_ready) begin
                if (expq.size() > 0) void'(expq.pop_front());
                done_count++;
            end
            if (in_valid && in_ready) begin
                expq.push_back(model(64'(in_a), 64'(in_b), in_sub, W));
                if (b2b) begin
                    if (b2b_acc > 0) check("initiation_interval", 64'(cyc - prev_acc), NS + 2);
                    b2b_acc++;
                end
                prev_acc = cyc;
                acc_cyc  = cyc;
                acc_count++;
            end
        end
    end

    // Compare process: every cycle a result is presented, it must match the model.
    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            pv = 1'b0;
        end else begin
            if (out_valid) begin
                if (expq.size() == 0) begin
                    check("spurious_out_valid", 64'(out_valid), 64'd0);
                end else begin
                    check("model_sum", 64'(out_sum), expq[0].sum);
                    check("model_cout", 64'(out_cout), 64'(expq[0].cout));
`ifdef ADDER_SEQ_OVF_EN
                    check("model_ovf", 64'(out_ovf), 64'(expq[0].ovf));
`endif
                end
                if (!pv) check("latency", 64'(cyc - acc_cyc), NS);
                check("in_ready_low_in_done", 64'(in_ready), 64'd0);
            end
            pv = out_valid;
        end
    end

    task automatic send(logic [W-1:0] a, logic [W-1:0] b, logic sub);
        int start;
        bit ok;
        start = acc_count;
        ok    = 1'b0;
        @(negedge clk);
        in_a     = a;
        in_b     = b;
        in_sub   = sub;
        in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (acc_count > start) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("accept_timeout", 64'd1, 64'd0);
        @(negedge clk);
        // Scramble inputs after accept: they must not affect the running operation.
        in_valid = 1'b0;
        in_a     = $urandom;
        in_b     = $urandom;
        in_sub   = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_valid();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (out_valid) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) check("out_valid_timeout", 64'd1, 64'd0);
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic run_op(logic [W-1:0] a, logic [W-1:0] b, logic sub, logic [W-1:0] es,
                          logic ec, string name);
        send(a, b, sub);
        wait_valid();
        check({name, "_sum"}, 64'(out_sum), 64'(es));
        check({name, "_cout"}, 64'(out_cout), 64'(ec));
        consume();
    endtask

`ifdef ADDER_SEQ_OVF_EN
    logic       v8_in_valid = 1'b0;
    logic       v8_in_ready;
    logic [7:0] v8_in_a = '0;
    logic [7:0] v8_in_b = '0;
    logic       v8_in_sub = 1'b0;
    logic       v8_out_valid;
    logic       v8_out_ready = 1'b0;
    logic [7:0] v8_out_sum;
    logic       v8_out_cout;
    logic       v8_out_ovf;

    adder_seq_ctrl #(.WIDTH(8)) dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (v8_in_valid),
        .in_ready  (v8_in_ready),
        .in_a      (v8_in_a),
        .in_b      (v8_in_b),
        .in_sub    (v8_in_sub),
        .out_valid (v8_out_valid),
        .out_ready (v8_out_ready),
        .out_sum   (v8_out_sum),
        .out_cout  (v8_out_cout),
        .out_ovf   (v8_out_ovf)
    );

    task automatic op8(logic [7:0] a, logic [7:0] b, logic sub, logic [7:0] es, logic eo,
                       logic ec, string name);
        @(negedge clk);
        check({name, "_ready"}, 64'(v8_in_ready), 64'd1);
        v8_in_a     = a;
        v8_in_b     = b;
        v8_in_sub   = sub;
        v8_in_valid = 1'b1;
        @(negedge clk);
        v8_in_valid = 1'b0;
        check({name, "_valid_early"}, 64'(v8_out_valid), 64'd0);
        @(negedge clk);
        check({name, "_valid"}, 64'(v8_out_valid), 64'd1);
        check({name, "_sum"}, 64'(v8_out_sum), 64'(es));
        check({name, "_ovf"}, 64'(v8_out_ovf), 64'(eo));
        check({name, "_cout"}, 64'(v8_out_cout), 64'(ec));
        v8_out_ready = 1'b1;
        @(negedge clk);
        v8_out_ready = 1'b0;
    endtask
`endif

    initial begin
        res_t        pin;
        int          acc_before;
        int          target;
        logic [W-1:0] ra, rb;

        // Pin the reference model with hand-computed values.
        pin = model(64'hFFFF_FFFF, 64'h1, 1'b0, 32);
        check("pin_add_wrap", {pin.sum[62:0], pin.cout}, {63'h0, 1'b1});
        pin = model(64'h5, 64'h7, 1'b1, 32);
        check("pin_sub_borrow", {pin.sum[62:0], pin.cout}, {63'hFFFF_FFFE, 1'b0});
        pin = model(64'h7F, 64'h1, 1'b0, 8);
        check("pin_ovf8", {pin.sum[61:0], pin.ovf, pin.cout}, {62'h80, 1'b1, 1'b0});

        #1;
        check("reset_in_ready", 64'(in_ready), 64'd1);
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_out_sum", 64'(out_sum), 64'd0);
        check("reset_out_cout", 64'(out_cout), 64'd0);
`ifdef ADDER_SEQ_OVF_EN
        check("reset_out_ovf", 64'(out_ovf), 64'd0);
`endif
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, "add_wrap");
        run_op(32'h0000_0005, 32'h0000_0007, 1'b1, 32'hFFFF_FFFE, 1'b0, "sub_neg");
        run_op(32'h1234_5678, 32'h1234_5678, 1'b1, 32'h0000_0000, 1'b1, "sub_equal");

        // Backpressure with a competing request held during DONE.
        send(32'hFFFF_0000, 32'h0000_0001, 1'b1);
        wait_valid();
        acc_before = acc_count;
        in_valid   = 1'b1;
        in_a       = $urandom;
        in_b       = $urandom;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_sum", 64'(out_sum), 64'hFFFE_FFFF);
            check("bp_in_ready", 64'(in_ready), 64'd0);
            check("bp_out_valid", 64'(out_valid), 64'd1);
        end
        consume();
        in_valid = 1'b0;
        check("bp_no_capture", 64'(acc_count), 64'(acc_before));

        // Reset in the middle of RUN, after slice 1 has been written.
        send(32'hDEAD_BEEF, 32'h0123_4567, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_run_out_valid", 64'(out_valid), 64'd0);
        check("rst_run_out_sum", 64'(out_sum), 64'd0);
        check("rst_run_in_ready", 64'(in_ready), 64'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", 64'(in_ready), 64'd1);
        check("post_rst_out_valid", 64'(out_valid), 64'd0);
        run_op(32'h0000_0100, 32'h0000_0100, 1'b0, 32'h0000_0200, 1'b0, "after_reset");

        // Isolated random operations, mixed add/sub, checked by the model.
        for (int i = 0; i < 6; i++) begin
            ra = (i == 0) ? 32'h8000_0000 : $urandom;
            rb = (i == 0) ? 32'h8000_0000 : $urandom;
            send(ra, rb, 1'($urandom_range(0, 1)));
            wait_valid();
            consume();
        end

        // Back-to-back with both handshakes held high.
        target = done_count + 8;
        b2b    = 1'b1;
        b2b_acc = 0;
        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int k = 0; k < 8; k++) begin
            acc_before = acc_count;
            in_a   = $urandom;
            in_b   = $urandom;
            in_sub = 1'($urandom_range(0, 1));
            for (int i = 0; i < 20; i++) begin
                @(posedge clk);
                #1;
                if (acc_count > acc_before) break;
            end
            if (acc_count == acc_before) check("b2b_accept_timeout", 64'd1, 64'd0);
            @(negedge clk);
        end
        in_valid = 1'b0;
        for (int i = 0; i < 20 && done_count < target; i++) @(negedge clk);
        check("b2b_results_consumed", 64'(done_count), 64'(target));
        check("b2b_accept_count", 64'(b2b_acc), 64'd8);
        out_ready = 1'b0;
        b2b       = 1'b0;

`ifdef ADDER_SEQ_OVF_EN
        op8(8'h7F, 8'h01, 1'b0, 8'h80, 1'b1, 1'b0, "ovf8_add");
        op8(8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1, "ovf8_sub");
        op8(8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0, "ovf8_plain");
`endif

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
